// File: rtl/canvas_painter.sv
// Frame-buffer write engine: turns paint requests into a brush stamp and clear
// requests into a full-canvas sweep, one pixel write per cycle.
// Optional feature: define ROUND_BRUSH_EN for a disc-shaped brush (default square).
module canvas_painter #(
  parameter int unsigned H_RES       = 320,
  parameter int unsigned V_RES       = 240,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned COLOR_W     = 12,
  parameter int unsigned BRUSH_MAX   = 4,
  parameter int unsigned R_W         = 3,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = 12'hFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_req,
  input  logic               paint_req,
  input  logic [9:0]         paint_x,
  input  logic [9:0]         paint_y,
  input  logic [R_W-1:0]     brush_r,
  input  logic [COLOR_W-1:0] paint_color,
  input  logic               erase,
  output logic               busy,
  output logic               paint_ack,
  output logic               clear_done,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data
);

  localparam int unsigned CW   = 11;
  localparam int unsigned PIX  = H_RES * V_RES;
  localparam logic [R_W-1:0]    R_MAX     = R_W'(BRUSH_MAX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX - 1);
`ifdef ROUND_BRUSH_EN
  localparam int unsigned SQ_W = 2 * R_W + 1;
`endif

  typedef enum logic [1:0] {IDLE, PAINT, CLEAR, DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cx, cy, dx, dy;
  logic [CW-1:0]       cx_nxt, cy_nxt, dx_nxt, dy_nxt;
  logic [R_W-1:0]      rad, rad_nxt;
  logic [COLOR_W-1:0]  col, col_nxt;
  logic [ADDR_W-1:0]   caddr, caddr_nxt;
  logic                pend, pend_nxt;

  logic                busy_nxt, ack_nxt, done_nxt, wr_en_nxt;
  logic [ADDR_W-1:0]   wr_addr_nxt;
  logic [COLOR_W-1:0]  wr_data_nxt;

  logic                emit_paint, emit_clear;
  logic [CW-1:0]       px, py;
  logic                in_canvas, in_disc, hit;
`ifdef ROUND_BRUSH_EN
  logic [R_W-1:0]      ax, ay;
`endif

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cx         <= '0;
      cy         <= '0;
      dx         <= '0;
      dy         <= '0;
      rad        <= '0;
      col        <= '0;
      caddr      <= '0;
      pend       <= 1'b0;
      busy       <= 1'b0;
      paint_ack  <= 1'b0;
      clear_done <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      state      <= state_nxt;
      cx         <= cx_nxt;
      cy         <= cy_nxt;
      dx         <= dx_nxt;
      dy         <= dy_nxt;
      rad        <= rad_nxt;
      col        <= col_nxt;
      caddr      <= caddr_nxt;
      pend       <= pend_nxt;
      busy       <= busy_nxt;
      paint_ack  <= ack_nxt;
      clear_done <= done_nxt;
      wr_en      <= wr_en_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
    end
  end

  // Next state; the registers hold the offset/address currently on the port
  always_comb begin
    state_nxt  = state;
    cx_nxt     = cx;
    cy_nxt     = cy;
    dx_nxt     = dx;
    dy_nxt     = dy;
    rad_nxt    = rad;
    col_nxt    = col;
    caddr_nxt  = caddr;
    pend_nxt   = pend;
    ack_nxt    = 1'b0;
    done_nxt   = 1'b0;
    emit_paint = 1'b0;
    emit_clear = 1'b0;

    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (clear_req) begin
          state_nxt  = CLEAR;
          caddr_nxt  = '0;
          emit_clear = 1'b1;
        end else if (paint_req) begin
          state_nxt  = PAINT;
          cx_nxt     = {1'b0, paint_x};
          cy_nxt     = {1'b0, paint_y};
          rad_nxt    = (brush_r > R_MAX) ? R_MAX : brush_r;
          col_nxt    = erase ? CLEAR_COLOR : paint_color;
          dx_nxt     = CW'(0) - CW'(rad_nxt);
          dy_nxt     = CW'(0) - CW'(rad_nxt);
          ack_nxt    = 1'b1;
          emit_paint = 1'b1;
        end
      end

      PAINT: begin
        pend_nxt = pend | clear_req;
        if (dx == CW'(rad) && dy == CW'(rad)) begin
          if (pend_nxt) begin
            // Pending clear starts on the very next cycle, no IDLE gap
            state_nxt  = CLEAR;
            pend_nxt   = 1'b0;
            caddr_nxt  = '0;
            emit_clear = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          emit_paint = 1'b1;
          if (dx == CW'(rad)) begin
            dx_nxt = CW'(0) - CW'(rad);
            dy_nxt = dy + CW'(1);
          end else begin
            dx_nxt = dx + CW'(1);
          end
        end
      end

      CLEAR: begin
        if (caddr == LAST_ADDR) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          caddr_nxt  = caddr + ADDR_W'(1);
          emit_clear = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = emit_paint | emit_clear;
  end

  // Target pixel of the next paint offset and the resulting write port values
  always_comb begin
    px        = cx_nxt + dx_nxt;
    py        = cy_nxt + dy_nxt;
    in_canvas = !px[CW-1] && !py[CW-1] && (px < CW'(H_RES)) && (py < CW'(V_RES));
`ifdef ROUND_BRUSH_EN
    ax      = dx_nxt[CW-1] ? R_W'(CW'(0) - dx_nxt) : R_W'(dx_nxt);
    ay      = dy_nxt[CW-1] ? R_W'(CW'(0) - dy_nxt) : R_W'(dy_nxt);
    in_disc = (SQ_W'(ax) * SQ_W'(ax) + SQ_W'(ay) * SQ_W'(ay))
              <= (SQ_W'(rad_nxt) * SQ_W'(rad_nxt));
`else
    in_disc = 1'b1;
`endif
    hit         = emit_paint && in_canvas && in_disc;
    wr_en_nxt   = emit_clear || hit;
    wr_addr_nxt = '0;
    wr_data_nxt = '0;
    if (emit_clear) begin
      wr_addr_nxt = caddr_nxt;
      wr_data_nxt = CLEAR_COLOR;
    end else if (hit) begin
      wr_addr_nxt = ADDR_W'(py) * ADDR_W'(H_RES) + ADDR_W'(px);
      wr_data_nxt = col_nxt;
    end
  end

endmodule

// File: tb/tb_canvas_painter.sv
// Self-checking bench for canvas_painter on a reduced 64x48 canvas; paint streams
// are checked against a per-cycle reference built from nested offset loops.
module tb_canvas_painter;

  localparam int H   = 64;
  localparam int V   = 48;
  localparam int PIX = H * V;
  localparam int BMAX = 4;
  localparam int CLR  = 'hFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_req, paint_req, erase;
  logic [9:0]  paint_x, paint_y;
  logic [2:0]  brush_r;
  logic [11:0] paint_color;
  logic        busy, paint_ack, clear_done, wr_en;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;

  canvas_painter #(.H_RES(H), .V_RES(V)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .paint_req(paint_req),
    .paint_x(paint_x), .paint_y(paint_y), .brush_r(brush_r),
    .paint_color(paint_color), .erase(erase), .busy(busy), .paint_ack(paint_ack),
    .clear_done(clear_done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct { bit en; int addr; int data; } exp_t;
  typedef struct { int x; int y; int r; int col; bit er; int exp_writes; int exp_cycles; } vec_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference brush: every offset of the (2r+1)^2 square in row-major order
  function automatic void build_paint(input int cx, input int cy, input int rr,
                                      input int col, input bit er);
    int r;
    r = (rr > BMAX) ? BMAX : rr;
    exp_q.delete();
    for (int dy = -r; dy <= r; dy++) begin
      for (int dx = -r; dx <= r; dx++) begin
        int x;
        int y;
        bit on;
        exp_t e;
        x  = cx + dx;
        y  = cy + dy;
        on = (x >= 0) && (x < H) && (y >= 0) && (y < V);
`ifdef ROUND_BRUSH_EN
        on = on && (dx * dx + dy * dy <= r * r);
`endif
        e.en   = on;
        e.addr = on ? y * H + x : 0;
        e.data = er ? CLR : col;
        exp_q.push_back(e);
      end
    end
  endfunction

  // Request a stamp, check every cycle of it; clr_at >= 0 pulses clear_req mid-stamp
  task automatic do_paint(input string name, input int x, input int y, input int r,
                          input int col, input bit er, input int clr_at,
                          output int writes, output int cycles);
    int mism;
    int first;
    mism = 0; first = -1; writes = 0; cycles = 0;
    paint_x = 10'(x); paint_y = 10'(y); brush_r = 3'(r);
    paint_color = 12'(col); erase = er; paint_req = 1'b1;
    @(posedge clk);
    build_paint(x, y, r, col, er);
    for (int i = 0; i < exp_q.size(); i++) begin
      bit ok;
      @(negedge clk);
      if (busy) cycles++;
      if (wr_en) writes++;
      ok = (busy === 1'b1) && (wr_en === exp_q[i].en) && (paint_ack === (i == 0))
           && (clear_done === 1'b0) && (int'(wr_addr) == exp_q[i].addr)
           && (!exp_q[i].en || int'(wr_data) == exp_q[i].data);
      if (!ok) begin
        mism++;
        if (first < 0) first = i;
      end
      if (i == 0) paint_req = 1'b0;
      if (i == clr_at) clear_req = 1'b1;
      if (i == clr_at + 1) clear_req = 1'b0;
    end
    clear_req = 1'b0;
    if (mism != 0) $display("  %s: first bad offset index %0d", name, first);
    chk({name, "_stream"}, mism, 0);
    if (clr_at < 0) begin
      @(negedge clk);
      chk({name, "_tail"}, int'({busy, wr_en, paint_ack}), 0);
    end
  endtask

  // Check a full clear sweep that starts on the next negedge, then its done cycle
  task automatic check_clear(input string name, input bit hold_paint);
    int mism;
    mism = 0;
    for (int i = 0; i < PIX; i++) begin
      @(negedge clk);
      if (!(busy === 1'b1 && wr_en === 1'b1 && int'(wr_addr) == i && wr_data === 12'hFFF
            && clear_done === 1'b0 && paint_ack === 1'b0)) mism++;
      if (hold_paint && i == 4) begin
        paint_x = 10'd10; paint_y = 10'd20; brush_r = 3'd0;
        paint_color = 12'hF00; erase = 1'b0; paint_req = 1'b1;
      end
    end
    chk({name, "_sweep"}, mism, 0);
    @(negedge clk);
    chk({name, "_done"}, int'({clear_done, busy, wr_en, paint_ack}), 4'b1000);
  endtask

  initial begin
    vec_t vt[5];
    int   w, c;

`ifdef ROUND_BRUSH_EN
    vt[0] = '{10, 20, 0, 'hF00, 1'b0, 1, 1};
    vt[1] = '{0, 0, 2, 'h0A5, 1'b0, 6, 25};
    vt[2] = '{30, 30, 7, 'h123, 1'b1, 49, 81};
    vt[3] = '{63, 47, 1, 'h777, 1'b0, 3, 9};
    vt[4] = '{1000, 5, 3, 'h00F, 1'b0, 0, 49};
`else
    vt[0] = '{10, 20, 0, 'hF00, 1'b0, 1, 1};
    vt[1] = '{0, 0, 2, 'h0A5, 1'b0, 9, 25};
    vt[2] = '{30, 30, 7, 'h123, 1'b1, 81, 81};
    vt[3] = '{63, 47, 1, 'h777, 1'b0, 4, 9};
    vt[4] = '{1000, 5, 3, 'h00F, 1'b0, 0, 49};
`endif

    rst = 1'b0; clear_req = 1'b0; paint_req = 1'b0; erase = 1'b0;
    paint_x = '0; paint_y = '0; brush_r = '0; paint_color = '0;
    #12;
    chk("rst_ctl", int'({busy, paint_ack, clear_done, wr_en}), 0);
    chk("rst_addr", int'(wr_addr), 0);
    chk("rst_data", int'(wr_data), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Full clear; a paint request held during it is accepted right after the done cycle
    clear_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("clear_first_addr", int'(wr_addr), 0);
    chk("clear_first_ctl", int'({busy, wr_en, paint_ack}), 3'b110);
    clear_req = 1'b0;
    begin
      int mism;
      mism = 0;
      for (int i = 1; i < PIX; i++) begin
        @(negedge clk);
        if (!(busy === 1'b1 && wr_en === 1'b1 && int'(wr_addr) == i && wr_data === 12'hFFF
              && clear_done === 1'b0 && paint_ack === 1'b0)) mism++;
        if (i == 4) begin
          paint_x = 10'd10; paint_y = 10'd20; brush_r = 3'd0;
          paint_color = 12'hF00; erase = 1'b0; paint_req = 1'b1;
        end
      end
      chk("clear_sweep", mism, 0);
    end
    @(negedge clk);
    chk("clear_done", int'({clear_done, busy, wr_en, paint_ack}), 4'b1000);
    build_paint(10, 20, 0, 'hF00, 1'b0);
    @(negedge clk);
    chk("held_paint_ack", int'({paint_ack, busy, wr_en, clear_done}), 4'b1110);
    chk("held_paint_addr", int'(wr_addr), 20 * H + 10);
    chk("held_paint_data", int'(wr_data), 'hF00);
    paint_req = 1'b0;
    @(negedge clk);
    chk("held_paint_tail", int'({busy, wr_en, paint_ack, clear_done}), 0);

    // Directed stamp table
    for (int k = 0; k < 5; k++) begin
      do_paint($sformatf("vec%0d", k), vt[k].x, vt[k].y, vt[k].r, vt[k].col, vt[k].er,
               -1, w, c);
      chk($sformatf("vec%0d_writes", k), w, vt[k].exp_writes);
      chk($sformatf("vec%0d_cycles", k), c, vt[k].exp_cycles);
    end

    // Randomised stamps, including partly and fully off-canvas centres
    for (int k = 0; k < 16; k++) begin
      do_paint($sformatf("rnd%0d", k), int'($urandom_range(0, 80)), int'($urandom_range(0, 60)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)),
               1'($urandom_range(0, 1)), -1, w, c);
    end

    // Clear pulsed mid-stamp: stamp completes, sweep follows with no gap, one done
    do_paint("midclr", 5, 5, 2, 'h0F0, 1'b0, 10, w, c);
    chk("midclr_cycles", c, 25);
    check_clear("midclr", 1'b0);
    begin
      int dones;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (clear_done) dones++;
      end
      chk("midclr_done_once", dones, 0);
    end

    // Simultaneous requests: clear wins; then reset mid-sweep
    paint_x = 10'd3; paint_y = 10'd3; brush_r = 3'd1; paint_color = 12'h321; erase = 1'b0;
    clear_req = 1'b1; paint_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("both_req_clear_wins", int'({busy, wr_en, paint_ack}), 3'b110);
    chk("both_req_addr", int'(wr_addr), 0);
    clear_req = 1'b0;
    repeat (50) @(negedge clk);
    paint_req = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ctl", int'({busy, paint_ack, clear_done, wr_en}), 0);
    chk("async_rst_addr", int'(wr_addr), 0);
    chk("async_rst_data", int'(wr_data), 0);
    @(negedge clk);
    rst = 1'b1;
    begin
      int act;
      act = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (busy || clear_done || wr_en || paint_ack) act++;
      end
      chk("post_rst_quiet", act, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
